psat_accum: RTL and testbench
=============================

# psat_accum

Packed-byte saturating accumulator that sits directly downstream of the packed signed-saturating byte adder in the SIMD execute path. It consumes a burst of 16-bit packed words (two signed 8-bit lanes). It folds them into a per-lane running sum using the same signed-saturation rule as the adder, then presents the final packed result once with a sticky per-lane saturation flag. It makes multi-operand packed reductions possible without re-issuing through the register file.

## Interface
- LEN_W, 8, width of the burst-length field; max burst = 2^LEN_W-1 words
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a burst; sampled only in IDLE
- len  in  LEN_W  number of words in the burst, sampled with start
- in_valid  in  1  in_data holds a valid packed word
- in_ready  out  1  block accepts in_data this cycle
- in_data  in  16  packed word: [15:8] lane 1, [7:0] lane 0, two's complement
- out_valid  out  1  out_data/sat_flag hold the final result
- out_ready  in  1  consumer takes result this cycle
- out_data  out  16  packed accumulated result
- sat_flag  out  2  per-lane sticky saturation ([1] = lane 1)
- busy  out  1  state != IDLE

## Operation
- States: IDLE, ACCUM, DONE. Encoding lives in the shared package.
- IDLE: in_ready=0, out_valid=0. On start: acc<=16'h0000, sat<=2'b00, remaining<=len. Go to ACCUM if len!=0, else DONE (result 0x0000, flags 00).
- ACCUM: in_ready=1. A beat is accepted when in_valid&in_ready. Per lane: acc_lane<=satadd(acc_lane, in_lane), sat_lane<=sat_lane|overflow_lane, remaining<=remaining-1. The accept that brings remaining to 0 moves to DONE.
- satadd(a,b): 8-bit wrap sum s. If a[7]=0, b[7]=0 and s[7]=1, the result is 0x7F with overflow. If a[7]=1, b[7]=1 and s[7]=0, the result is 0x80 with overflow. Otherwise the result is s and there is no overflow. Lanes are fully independent; no carry crosses bit 7/8.
- Saturation clamps only the current value. Later beats may pull the sum back off the rail. sat_flag never clears within a burst.
- DONE: out_valid=1, out_data=acc, sat_flag=sat, held stable until out_ready. On out_valid&out_ready, go to IDLE.
- start outside IDLE is ignored. in_valid outside ACCUM is ignored, and no beat is consumed.
- out_ready while not in DONE has no effect.

## Timing
- Reset (async, any state): state=IDLE, acc=0x0000, sat=00, remaining=0. Outputs are therefore in_ready=0, out_valid=0, out_data=0x0000, sat_flag=00, busy=0. A burst in progress is discarded; no partial result is emitted.
- start in cycle N puts the block in ACCUM in cycle N+1, so in_ready=1 from N+1.
- The last beat accepted in cycle M gives out_valid=1 in cycle M+1.
- Throughput in ACCUM is one beat per cycle. in_ready is a pure function of state, with no combinational path from in_valid.
- The result handshake in cycle K leaves the block in IDLE at K+1. start is accepted at K+1 at the earliest. Minimum burst period is len+2 cycles.
- len=0: start at N gives out_valid at N+1.
- All outputs are registered or state-decoded; there is no combinational input-to-output path.

## Structure
- Shared package: state encoding (IDLE/ACCUM/DONE), lane width 8, SAT_POS=8'h7F, SAT_NEG=8'h80.
- One sub-module, sat_lane_add: 8-bit combinational signed saturating add with an overflow output. It is instantiated twice, for lanes 0 and 1.
- Top level holds the FSM, the remaining-beat counter, the accumulator and the sticky flag registers.

## Test plan
- Positive lane clamp: len=2, beats 0x7010, 0x2020 -> out_data=0x7F30, sat_flag=2'b10, out_valid one cycle after the 2nd accept.
- Negative lane clamp: len=2, beats 0x80FF, 0xFF01 -> out_data=0x8000, sat_flag=2'b10. Lane 0 gives FF+01=00 with mixed signs, so no flag.
- Recover off rail, sticky flag: len=3, beats 0x7000, 0x7000, 0x8100 -> out_data=0x0000, sat_flag=2'b10.
- Zero-length and backpressure: start with len=0 -> out_valid the next cycle with 0x0000/00. Hold out_ready=0 for 5 cycles -> outputs stable. start pulses while in DONE are ignored.
- Gapped input: len=4, beats 0x0101 each with in_valid toggling every other cycle -> out_data=0x0404, sat_flag=00. remaining decrements only on accepts.
- Reset mid-burst: assert rst after 2 of 4 beats -> all outputs return to reset values immediately. A new burst of len=1 with beat 0x05FB -> out_data=0x05FB.

Source files
------------

// File: rtl/psat_accum_pkg.sv
// Shared definitions for the packed-byte saturating accumulator: FSM encoding,
// lane width and the saturation rails.
package psat_accum_pkg;

  localparam int LANE_W = 8;
  localparam int NUM_LANES = 2;

  localparam logic [LANE_W-1:0] SAT_POS = 8'h7F;
  localparam logic [LANE_W-1:0] SAT_NEG = 8'h80;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/psat_accum_if.sv
// Burst/result handshake bundle between the SIMD execute path and psat_accum.
interface psat_accum_if
  import psat_accum_pkg::*;
#(
  parameter int LEN_W = 8
);

  logic                          start;
  logic [LEN_W-1:0]              len;
  logic                          in_valid;
  logic                          in_ready;
  logic [NUM_LANES*LANE_W-1:0]   in_data;
  logic                          out_valid;
  logic                          out_ready;
  logic [NUM_LANES*LANE_W-1:0]   out_data;
  logic [NUM_LANES-1:0]          sat_flag;
  logic                          busy;

  modport master (
    output start, len, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, sat_flag, busy
  );

  modport slave (
    input  start, len, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, sat_flag, busy
  );

endinterface

// File: rtl/psat_accum_sat_lane_add.sv
// One 8-bit signed saturating adder lane; overflow is reported whenever the
// result was clamped to a rail.
module sat_lane_add
  import psat_accum_pkg::*;
(
  input  logic signed [LANE_W-1:0] a_i,
  input  logic signed [LANE_W-1:0] b_i,
  output logic signed [LANE_W-1:0] sum_o,
  output logic                     ovf_o
);

  // Returns {overflow, result}; overflow only when both operands share a sign
  // that the wrapped sum does not.
  function automatic logic [LANE_W:0] sat_add(input logic signed [LANE_W-1:0] a,
                                              input logic signed [LANE_W-1:0] b);
    logic signed [LANE_W-1:0] s;
    s = a + b;
    if (!a[LANE_W-1] && !b[LANE_W-1] && s[LANE_W-1])
      return {1'b1, SAT_POS};
    else if (a[LANE_W-1] && b[LANE_W-1] && !s[LANE_W-1])
      return {1'b1, SAT_NEG};
    else
      return {1'b0, s};
  endfunction

  assign {ovf_o, sum_o} = sat_add(a_i, b_i);

endmodule

// File: rtl/psat_accum.sv
// Packed two-lane saturating accumulator: folds a burst of packed words into a
// per-lane saturating sum and presents it once with sticky saturation flags.
module psat_accum
  import psat_accum_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input logic        clk,
  input logic        rst,
  psat_accum_if.slave bus
);

  state_e                        state_q, state_d;
  logic [NUM_LANES*LANE_W-1:0]   acc_q,   acc_d;
  logic [NUM_LANES-1:0]          sat_q,   sat_d;
  logic [LEN_W-1:0]              rem_q,   rem_d;

  logic signed [LANE_W-1:0]      sum0, sum1;
  logic                          ovf0, ovf1;

  sat_lane_add u_lane0 (
    .a_i   (acc_q[LANE_W-1:0]),
    .b_i   (bus.in_data[LANE_W-1:0]),
    .sum_o (sum0),
    .ovf_o (ovf0)
  );

  sat_lane_add u_lane1 (
    .a_i   (acc_q[2*LANE_W-1:LANE_W]),
    .b_i   (bus.in_data[2*LANE_W-1:LANE_W]),
    .sum_o (sum1),
    .ovf_o (ovf1)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      sat_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sat_d   = sat_q;
    rem_d   = rem_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          acc_d   = '0;
          sat_d   = '0;
          rem_d   = bus.len;
          state_d = (bus.len != '0) ? ST_ACCUM : ST_DONE;
        end
      end
      ST_ACCUM: begin
        // in_ready is constant in this state, so in_valid alone marks an accept.
        if (bus.in_valid) begin
          acc_d = {sum1, sum0};
          sat_d = sat_q | {ovf1, ovf0};
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1))
            state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == ST_ACCUM);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.out_data  = acc_q;
  assign bus.sat_flag  = sat_q;

endmodule

// File: tb/tb_psat_accum.sv
// Directed bench for psat_accum: integer-arithmetic burst model checked every
// cycle, plus literal expectations for each directed burst.
module tb_psat_accum;

  logic clk;
  logic rst;

  psat_accum_if #(.LEN_W(8)) bus ();

  psat_accum #(.LEN_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int lane(input logic [15:0] d, input int idx);
    logic [7:0] b;
    b = (idx != 0) ? d[15:8] : d[7:0];
    return int'($signed(b));
  endfunction

  function automatic int clamp8(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  function automatic logic clipped(input int v);
    return clamp8(v) != v;
  endfunction

  int         m_phase = 0;  // 0 idle, 1 collecting beats, 2 result held
  int         m_len = 0;
  int         m_got = 0;
  int         m_l0 = 0;
  int         m_l1 = 0;
  logic [1:0] m_sat = 2'b00;
  logic [15:0] m_exp;

  assign m_exp = {m_l1[7:0], m_l0[7:0]};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0;
      m_len   <= 0;
      m_got   <= 0;
      m_l0    <= 0;
      m_l1    <= 0;
      m_sat   <= 2'b00;
    end else if (m_phase == 0) begin
      if (bus.start) begin
        m_len   <= int'(bus.len);
        m_got   <= 0;
        m_l0    <= 0;
        m_l1    <= 0;
        m_sat   <= 2'b00;
        m_phase <= (bus.len == 0) ? 2 : 1;
      end
    end else if (m_phase == 1) begin
      if (bus.in_valid) begin
        m_l0     <= clamp8(m_l0 + lane(bus.in_data, 0));
        m_l1     <= clamp8(m_l1 + lane(bus.in_data, 1));
        m_sat[0] <= m_sat[0] | clipped(m_l0 + lane(bus.in_data, 0));
        m_sat[1] <= m_sat[1] | clipped(m_l1 + lane(bus.in_data, 1));
        m_got    <= m_got + 1;
        if (m_got + 1 == m_len) m_phase <= 2;
      end
    end else begin
      if (bus.out_ready) m_phase <= 0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready",  16'(bus.in_ready),  16'(m_phase == 1));
      chk("out_valid", 16'(bus.out_valid), 16'(m_phase == 2));
      chk("busy",      16'(bus.busy),      16'(m_phase != 0));
      if (m_phase == 2) begin
        chk("out_data", bus.out_data, m_exp);
        chk("sat_flag", 16'(bus.sat_flag), 16'(m_sat));
      end
    end
  end

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic start_burst(input logic [7:0] l);
    bus.start = 1'b1;
    bus.len   = l;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic send_beat(input logic [15:0] d, input bit gap);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(negedge clk);
    bus.in_valid = 1'b0;
    if (gap) begin
      bus.in_data = 16'hDEAD;
      @(negedge clk);
    end
  endtask

  task automatic finish_result(input string nm, input logic [15:0] exp_d,
                               input logic [1:0] exp_f, input int hold);
    int waited = 0;
    while (!bus.out_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk({nm, "_timeout"}, 16'(waited < 20), 16'd1);
    chk({nm, "_data"}, bus.out_data, exp_d);
    chk({nm, "_flag"}, 16'(bus.sat_flag), 16'(exp_f));
    // Backpressure with stray start/in_valid that must be ignored.
    for (int i = 0; i < hold; i++) begin
      bus.start    = 1'b1;
      bus.len      = 8'd3;
      bus.in_valid = 1'b1;
      bus.in_data  = 16'h7F7F;
      @(negedge clk);
      chk({nm, "_hold_valid"}, 16'(bus.out_valid), 16'd1);
      chk({nm, "_hold_data"}, bus.out_data, exp_d);
      chk({nm, "_hold_flag"}, 16'(bus.sat_flag), 16'(exp_f));
    end
    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({nm, "_idle_busy"}, 16'(bus.busy), 16'd0);
    chk({nm, "_idle_valid"}, 16'(bus.out_valid), 16'd0);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  16'(bus.in_ready), 16'd0);
    chk("rst_out_valid", 16'(bus.out_valid), 16'd0);
    chk("rst_out_data",  bus.out_data, 16'h0000);
    chk("rst_sat_flag",  16'(bus.sat_flag), 16'd0);
    chk("rst_busy",      16'(bus.busy), 16'd0);
    rst = 1'b0;
    @(negedge clk);

    // Positive clamp on lane 1, with a short backpressure hold.
    start_burst(8'd2);
    chk("t1_ready_after_start", 16'(bus.in_ready), 16'd1);
    send_beat(16'h7010, 1'b0);
    chk("t1_not_done_early", 16'(bus.out_valid), 16'd0);
    send_beat(16'h2020, 1'b0);
    chk("t1_latency", 16'(bus.out_valid), 16'd1);
    finish_result("t1", 16'h7F30, 2'b10, 3);

    // Negative clamp on lane 1; lane 0 mixed signs does not flag.
    start_burst(8'd2);
    send_beat(16'h80FF, 1'b0);
    send_beat(16'hFF01, 1'b0);
    finish_result("t2", 16'h8000, 2'b10, 0);

    // Pull back off the rail; flag stays sticky.
    start_burst(8'd3);
    send_beat(16'h7000, 1'b0);
    send_beat(16'h7000, 1'b0);
    send_beat(16'h8100, 1'b0);
    finish_result("t3", 16'h0000, 2'b10, 0);

    // Both lanes clamp negative.
    start_burst(8'd2);
    send_beat(16'h9090, 1'b0);
    send_beat(16'hA0C0, 1'b0);
    finish_result("t4", 16'h8080, 2'b11, 0);

    // Zero-length burst with 5 cycles of backpressure.
    start_burst(8'd0);
    chk("t5_latency", 16'(bus.out_valid), 16'd1);
    finish_result("t5", 16'h0000, 2'b00, 5);

    // Gapped input.
    start_burst(8'd4);
    for (int i = 0; i < 3; i++) send_beat(16'h0101, 1'b1);
    chk("t6_still_accum", 16'(bus.in_ready), 16'd1);
    send_beat(16'h0101, 1'b0);
    finish_result("t6", 16'h0404, 2'b00, 0);

    // Reset mid-burst, then a fresh single-beat burst.
    start_burst(8'd4);
    send_beat(16'h1111, 1'b0);
    send_beat(16'h2222, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("t7_rst_in_ready",  16'(bus.in_ready), 16'd0);
    chk("t7_rst_out_valid", 16'(bus.out_valid), 16'd0);
    chk("t7_rst_out_data",  bus.out_data, 16'h0000);
    chk("t7_rst_sat_flag",  16'(bus.sat_flag), 16'd0);
    chk("t7_rst_busy",      16'(bus.busy), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start_burst(8'd1);
    send_beat(16'h05FB, 1'b0);
    finish_result("t7", 16'h05FB, 2'b00, 0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
